// File: rtl/parameters_pkg.sv
// Shared field parameters and Montgomery-conversion types for the Ed448 datapath.
package parameters_pkg;

    localparam int DATA_WIDTH = 448;

    // Ed448 prime p = 2^448 - 2^224 - 1: all ones except bit 224.
    localparam logic [DATA_WIDTH-1:0] MODULUS = {{223{1'b1}}, 1'b0, {224{1'b1}}};

    localparam int CONV_CNT_W = $clog2(DATA_WIDTH);

    localparam logic CONV_TO_MONT   = 1'b0;
    localparam logic CONV_FROM_MONT = 1'b1;

    typedef enum logic {
        IDLE,
        ITER
    } conv_state_t;

    // Any W-bit value is below 2p, so a single conditional subtract reduces it.
    function automatic logic [DATA_WIDTH-1:0] reduce_once(input logic [DATA_WIDTH-1:0] v);
        return (v >= MODULUS) ? (v - MODULUS) : v;
    endfunction

endpackage

// File: rtl/mont_conv_step.sv
// One combinational conversion step: modular doubling (to-Montgomery)
// or modular halving (from-Montgomery). Width and modulus are overridable for small-modulus checks.
module mont_conv_step
    import parameters_pkg::*;
#(
    parameter int             W = DATA_WIDTH,
    parameter logic [W-1:0]   P = MODULUS
) (
    input  logic [W-1:0] x,
    input  logic         dir,
    output logic [W-1:0] x_next
);

    logic [W:0] dbl;
    logic [W:0] dbl_sub;
    logic [W:0] half_sum;
    logic       unused_bits;

    assign dbl      = {x, 1'b0};
    assign dbl_sub  = dbl - {1'b0, P};
    // Adding p when x is odd makes the sum even, so the shift is an exact halving.
    assign half_sum = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};

    // With x < p these bits are always zero where they would be used.
    assign unused_bits = ^{dbl_sub[W], half_sum[0]};

    always_comb begin
        x_next = '0;
        if (dir == CONV_TO_MONT) begin
            x_next = (dbl >= {1'b0, P}) ? dbl_sub[W-1:0] : dbl[W-1:0];
        end else begin
            x_next = half_sum[W:1];
        end
    end

endmodule

// File: rtl/mont_convert.sv
// Sequential converter to/from the Montgomery domain (R = 2^DATA_WIDTH),
// one modular doubling or halving per clock, DATA_WIDTH steps per conversion.
module mont_convert
    import parameters_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic                  busy
);

    localparam logic [CONV_CNT_W-1:0] LAST_STEP = CONV_CNT_W'(DATA_WIDTH - 1);

    conv_state_t             state_reg;
    logic                    dir_reg;
    logic [CONV_CNT_W-1:0]   count_reg;
    logic [DATA_WIDTH-1:0]   x_reg;
    logic [DATA_WIDTH-1:0]   x_next;
    logic [DATA_WIDTH-1:0]   result_reg;
    logic                    done_reg;
    logic                    busy_reg;

    mont_conv_step #(
        .W (DATA_WIDTH),
        .P (MODULUS)
    ) u_step (
        .x      (x_reg),
        .dir    (dir_reg),
        .x_next (x_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            dir_reg    <= CONV_TO_MONT;
            count_reg  <= '0;
            x_reg      <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        x_reg     <= reduce_once(a);
                        dir_reg   <= dir;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ITER;
                    end
                end
                ITER: begin
                    x_reg     <= x_next;
                    count_reg <= count_reg + 1'b1;
                    done_reg  <= 1'b0;
                    // Final step lands directly in the output register; result holds until the next done.
                    if (count_reg == LAST_STEP) begin
                        result_reg <= x_next;
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign result = result_reg;
    assign done   = done_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_mont_convert.sv
// Scoreboard bench for mont_convert: a driver queues expected results, a monitor checks each done.
module tb_mont_convert;
    import parameters_pkg::*;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [1023:0]         wide_t;

    typedef struct {
        word_t res;
        int    edge_no;
        string name;
    } exp_t;

    localparam int    LATENCY = DATA_WIDTH;
    localparam word_t P       = MODULUS;
    localparam word_t T224    = word_t'(1) << 224;
    localparam word_t R_MOD_P = T224 + word_t'(1);
    // R^-1 mod p = 2 - 2^224 mod p = 2^448 - 2^225 + 1 (since 2^448 = 2^224 + 1 mod p).
    localparam word_t RINV    = {DATA_WIDTH{1'b1}} - (word_t'(1) << 225) + word_t'(2);

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  start = 1'b0;
    logic  dir = 1'b0;
    word_t a = '0;
    word_t result;
    logic  done;
    logic  busy;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    exp_t  sb[$];
    word_t last_exp = '0;
    logic  prev_done = 1'b0;

    mont_convert dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dir    (dir),
        .a      (a),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check_w(input string nm, input word_t act, input word_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic word_t enc_model(input word_t v);
        wide_t t;
        t = {576'b0, v} << DATA_WIDTH;
        return word_t'(t % {576'b0, P});
    endfunction

    function automatic word_t dec_model(input word_t v);
        wide_t t;
        t = ({576'b0, v} * {576'b0, RINV}) % {576'b0, P};
        return word_t'(t);
    endfunction

    function automatic word_t rand_below_p();
        word_t r;
        for (int i = 0; i < DATA_WIDTH / 32; i++) r[i*32 +: 32] = $urandom();
        if (r >= P) r = r - P;
        return r;
    endfunction

    // Monitor: pops one expectation per done pulse, checks value and latency.
    always @(negedge clk) begin
        if (done) begin
            if (prev_done) check_i("done_width", 2, 1);
            if (sb.size() == 0) begin
                check_i("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_w({e.name, "_result"}, result, e.res);
                check_i({e.name, "_latency"}, cyc - e.edge_no, LATENCY);
                last_exp = e.res;
                $display("txn %s result=%h latency=%0d", e.name, result, cyc - e.edge_no);
            end
        end
        prev_done = done;
    end

    // Waits for idle (done cycle counts), then presents one start pulse.
    task automatic issue(input logic d, input word_t v, input word_t exp_res,
                         input string nm, input bit push);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy && guard < 2000);
        if (busy) check_i({nm, "_wait_idle_timeout"}, guard, 0);
        start = 1'b1;
        dir   = d;
        a     = v;
        if (push) begin
            exp_t e;
            e.res = exp_res;
            e.edge_no = cyc + 1;
            e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check_i({nm, "_busy_after_start"}, int'(busy), 1);
        check_w({nm, "_result_held"}, result, last_exp);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((sb.size() != 0 || busy) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_i("drain_pending", sb.size(), 0);
    endtask

    initial begin
        word_t v;
        word_t e;
        bit    all_busy;

        repeat (3) @(negedge clk);
        check_w("reset_result", result, '0);
        check_i("reset_done", int'(done), 0);
        check_i("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // Zero and encode/decode of one, issued back-to-back.
        issue(CONV_TO_MONT,   '0,      '0,          "enc_zero", 1'b1);
        issue(CONV_FROM_MONT, '0,      '0,          "dec_zero", 1'b1);
        issue(CONV_TO_MONT,   word_t'(1), R_MOD_P,  "enc_one",  1'b1);
        issue(CONV_FROM_MONT, R_MOD_P, word_t'(1),  "dec_rmodp", 1'b1);

        // Inputs at or above p.
        issue(CONV_TO_MONT,   P,                   '0,                  "enc_p",       1'b1);
        issue(CONV_TO_MONT,   P + word_t'(1),      R_MOD_P,             "enc_p_plus1", 1'b1);
        issue(CONV_FROM_MONT, {DATA_WIDTH{1'b1}},  T224 - word_t'(1),   "dec_all_ones", 1'b1);
        issue(CONV_FROM_MONT, T224,                T224 - word_t'(1),   "dec_2_224",   1'b1);

        // Round trips on random operands.
        for (int i = 0; i < 6; i++) begin
            v = rand_below_p();
            e = enc_model(v);
            issue(CONV_TO_MONT,   v, e, "rt_enc", 1'b1);
            issue(CONV_FROM_MONT, e, v, "rt_dec", 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            v = rand_below_p();
            issue(CONV_FROM_MONT, v, dec_model(v), "dec_rand", 1'b1);
        end

        // Start pulses during a conversion must be ignored.
        issue(CONV_TO_MONT, word_t'(5), (word_t'(5) << 224) + word_t'(5), "enc_five_busy", 1'b1);
        all_busy = 1'b1;
        for (int i = 1; i <= LATENCY - 2; i++) begin
            @(negedge clk);
            all_busy &= busy;
            if (i == 9 || i == 199) begin
                start = 1'b1;
                dir   = CONV_FROM_MONT;
                a     = 448'h1234_5678_9abc;
            end else begin
                start = 1'b0;
            end
        end
        check_i("busy_throughout", int'(all_busy), 1);
        wait_drain();

        // Reset in the middle of a conversion: state discarded, no done.
        issue(CONV_TO_MONT, word_t'(7), '0, "enc_reset_mid", 1'b0);
        repeat (98) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_i("rst_mid_busy", int'(busy), 0);
        check_i("rst_mid_done", int'(done), 0);
        check_w("rst_mid_result", result, '0);
        last_exp = '0;
        repeat (LATENCY + 20) @(negedge clk);

        issue(CONV_TO_MONT, word_t'(3), (word_t'(3) << 224) + word_t'(3), "enc_after_reset", 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mont_convert.md
# mont_convert

Sequential converter between the standard representation and the Montgomery domain of Fp, with R = 2^DATA_WIDTH. In to-Montgomery mode it computes a·R mod p by DATA_WIDTH modular doublings. In from-Montgomery mode it computes a·R⁻¹ mod p by DATA_WIDTH modular halvings. It uses no multiplier and sits on both sides of the Montgomery multiplier: field operands are encoded before multiplication and results are decoded after.

## Interface
Parameters (from `parameters_pkg`, not overridable per instance):
- DATA_WIDTH, 448, operand width; R = 2^DATA_WIDTH.
- MODULUS, Ed448 p = 2^448 − 2^224 − 1, must be odd, with 2^(DATA_WIDTH−1) < p < 2^DATA_WIDTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- dir  in  1  0 = to-Montgomery (a·R mod p), 1 = from-Montgomery (a·R⁻¹ mod p); sampled with start.
- a  in  DATA_WIDTH  operand, any value in [0, 2^DATA_WIDTH); sampled with start.
- result  out  DATA_WIDTH  converted value, always < p.
- done  out  1  one-cycle pulse; result valid.
- busy  out  1  high while a conversion is in progress.

## Operation
States (`conv_state_t`) are IDLE and ITER.

- **Reset:** when rst is high at a posedge:
  - state ← IDLE; result ← 0; done ← 0; busy ← 0; counter ← 0.
  - Reset overrides everything, including mid-ITER; a partial conversion is discarded and no done is produced.
- **IDLE, start = 1:**
  - Load x ← (a ≥ p) ? a − p : a. One subtract suffices because a < 2p.
  - Latch dir; counter ← 0; busy ← 1; done ← 0; state ← ITER.
- **IDLE, start = 0:**
  - done ← 0; result holds.
- **ITER:** one step per cycle.
  - dir = 0: y = 2x on DATA_WIDTH+1 bits; x ← (y ≥ p) ? y − p : y.
  - dir = 1: y = x[0] ? x + p : x on DATA_WIDTH+1 bits; x ← y >> 1.
  - Both steps keep x < p invariant.
  - counter increments each step. On the step where counter = DATA_WIDTH−1:
    - result ← step output; done ← 1; busy ← 0; state ← IDLE.
- **start while busy:** ignored. a and dir changes are ignored after the load cycle.
- **result:** stable from the done pulse until the next done, or until reset. It is not cleared on the next start.

## Timing
- Start sampled at edge k → done high during the cycle after edge k + DATA_WIDTH, i.e. 448 cycles after the start edge.
- busy is high from after edge k until after edge k + DATA_WIDTH.
- **Back-to-back:** start may be asserted in the cycle done is high. It is accepted at the next edge, where done drops. Throughput is one conversion per DATA_WIDTH cycles.
- done is exactly one cycle wide unless reset intervenes.
- counter is ⌈log2 DATA_WIDTH⌉ bits and never wraps; it is reloaded at each start.
- Critical path is one (DATA_WIDTH+1)-bit add or subtract plus compare and mux. No multi-cycle paths.

## Structure
- Add to `parameters_pkg`:
  - `conv_state_t` (IDLE, ITER).
  - Constants `CONV_TO_MONT` = 1'b0 and `CONV_FROM_MONT` = 1'b1.
  - `CONV_CNT_W` = $clog2(DATA_WIDTH).
- Sub-module `mont_conv_step` is purely combinational:
  - Inputs: x, dir. Output: next x.
  - Contains the double-and-reduce and the add-p-and-halve datapaths.
  - Testable standalone against small-modulus reference values.
- `mont_convert` holds only the FSM, counter, x register, load reduction and output registers.

## Test plan
- **Zero:** dir = 0, a = 0 → result 0. Then dir = 1, a = 0 → result 0. Each done fires exactly 448 cycles after its start edge.
- **Encode one:** dir = 0, a = 1 → result = 2^224 + 1 (R mod p). Then dir = 1, a = 2^224 + 1 → result = 1.
- **Input ≥ p:**
  - dir = 0, a = p → result 0.
  - dir = 0, a = p + 1 → result 2^224 + 1.
  - dir = 1, a = 2^448 − 1 → same result as a = 2^224 (= (2^448 − 1) − p).
- **Round trip and handshake:**
  - 1000 random a < p: encode then decode → result = a.
  - Encode result must equal a·2^448 mod p from the bench model.
  - Back-to-back start on the done cycle; done never wider than one cycle.
- **Start while busy:** pulse start with different a and dir at cycles 10 and 200 of a conversion → ignored; original result is unchanged; busy stays high throughout.
- **Reset mid-operation:** assert rst at cycle 100 of a conversion → next cycle state IDLE, busy 0, done 0, result 0. No done follows. A fresh start then completes correctly in 448 cycles.
